main_memory_ctrl: RTL

MAIN_MEMORY_CTRL -- requirements
Module: main_memory_ctrl

---
 rtl/main_memory_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/main_memory_ctrl.sv
// Word-addressed 16-bit main memory behind a level request / ready pulse
// handshake, returning read data on a shared tristate bus.
module main_memory_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] MAR_addr,
    inout  wire  [15:0]       MM_data,
    input  logic              write_to_MM,
    input  logic              read_from_MM,
    output logic              MM_ready,
    output logic              MM_busy,
    output logic              MM_error
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              op_q;
    logic [15:0]       wdata_q;
    logic [15:0]       rdata_q;
    logic              err_q;
    logic              one_req;
    logic              both_req;
    logic              drive;

    // Contents survive reset; only configuration clears them.
    logic [15:0] mem [2**ADDR_W] = '{default: '0};

    assign one_req  = write_to_MM ^ read_from_MM;
    assign both_req = write_to_MM & read_from_MM;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (one_req) state_nx = WAIT;
            WAIT:    if (cnt == 4'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= 4'd0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && both_req;
            if (state == IDLE && one_req)
                cnt <= CNT_INIT;
            else if (state == WAIT && cnt != 4'd0)
                cnt <= cnt - 4'd1;
        end
    end

    // op_q is 1 for a write; latched operands are only trusted from WAIT on.
    always_ff @(posedge clk) begin
        if (state == IDLE && one_req) begin
            addr_q <= MAR_addr;
            op_q   <= write_to_MM;
            if (write_to_MM) wdata_q <= MM_data;
        end
        if (state == WAIT && cnt == 4'd0) begin
            if (op_q) mem[addr_q] <= wdata_q;
            else      rdata_q     <= mem[addr_q];
        end
    end

    always_comb begin
        MM_ready = (state == DONE);
        MM_busy  = (state != IDLE);
        MM_error = err_q;
        drive    = (state == DONE) && !op_q
                   && read_from_MM && !write_to_MM;
    end

    assign MM_data = drive ? rdata_q : 16'bz;

endmodule
